// File: rtl/snn_interfaces_pkg.sv
// Shared SNN event types plus event-FIFO defaults and helpers.
package snn_interfaces_pkg;

    localparam int TIMESTEP_BITS  = 8;
    localparam int COORD_BITS     = 8;
    localparam int SPIKE_CHANNELS = 2;

    typedef struct packed {
        logic [TIMESTEP_BITS-1:0]  timestep;
        logic [COORD_BITS-1:0]     x;
        logic [COORD_BITS-1:0]     y;
        logic [SPIKE_CHANNELS-1:0] spikes;
    } output_vector_t;

    localparam int EVENT_FIFO_DEPTH_DEFAULT = 16;

    // An event that carries no spikes does no work downstream.
    function automatic logic is_empty_event(input output_vector_t ev);
        return ev.spikes == '0;
    endfunction

endpackage

// File: rtl/event_fifo_mem.sv
// Simple dual-port event storage: one write port, one registered write-first read port.
module event_fifo_mem
    import snn_interfaces_pkg::*;
#(
    parameter int DEPTH     = EVENT_FIFO_DEPTH_DEFAULT,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  output_vector_t       wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output output_vector_t       rd_data
);

    output_vector_t mem [DEPTH];

    // NOTE: storage and its read register carry no reset so they map onto RAM primitives;
    // validity is tracked entirely by the pointers in the parent.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write-first: a read of the slot being written returns the new word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/conv_event_fifo.sv
// Event FIFO feeding Convolution2d: drops empty events, flags timestep changes.
// Optional statistics outputs enabled by defining CONV_EVENT_FIFO_STATS_EN.
module conv_event_fifo
    import snn_interfaces_pkg::*;
#(
    parameter int IN_CHANNELS = 2,
    parameter int DEPTH       = EVENT_FIFO_DEPTH_DEFAULT,
    parameter int ADDR_BITS   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  output_vector_t       in_event,
    output logic                 out_valid,
    input  logic                 out_ready,
    output output_vector_t       out_event,
    output logic                 out_ts_new,
    output logic [ADDR_BITS:0]   count,
    output logic                 empty,
    output logic                 full
`ifdef CONV_EVENT_FIFO_STATS_EN
    ,
    output logic [31:0]          stat_accepted,
    output logic [31:0]          stat_dropped,
    output logic [ADDR_BITS:0]   stat_max_count
`endif
);

    if (IN_CHANNELS != SPIKE_CHANNELS || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("conv_event_fifo: IN_CHANNELS must match the event mask and DEPTH must be a power of 2 >= 2");
    end

    localparam logic [ADDR_BITS:0] PTR_ONE    = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

    logic [ADDR_BITS:0]       wr_ptr;
    logic [ADDR_BITS:0]       rd_ptr;
    logic [ADDR_BITS:0]       rd_ptr_next;
    logic [TIMESTEP_BITS-1:0] last_ts;
    logic                     last_ts_valid;
    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     rd_en;

    // Extra pointer MSB separates full from empty; the difference is the occupancy.
    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign accept      = in_valid && in_ready;
    assign push        = accept && !is_empty_event(in_event);
    assign pop         = out_valid && out_ready;
    assign rd_ptr_next = pop ? rd_ptr + PTR_ONE : rd_ptr;

    // Reload the head register whenever the next head differs from the current one,
    // but leave it untouched when the FIFO drains so out_event holds its last value.
    assign rd_en = (pop && ((count != PTR_ONE) || push)) || (push && empty);

    assign out_ts_new = out_valid && (!last_ts_valid || (out_event.timestep != last_ts));

    event_fifo_mem #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[ADDR_BITS-1:0]),
        .wr_data (in_event),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_next[ADDR_BITS-1:0]),
        .rd_data (out_event)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            last_ts       <= '0;
            last_ts_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr_next;
                last_ts       <= out_event.timestep;
                last_ts_valid <= 1'b1;
            end
        end
    end

`ifdef CONV_EVENT_FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accepted  <= '0;
            stat_dropped   <= '0;
            stat_max_count <= '0;
        end else begin
            if (push && (stat_accepted != '1)) begin
                stat_accepted <= stat_accepted + 32'd1;
            end
            if (accept && is_empty_event(in_event) && (stat_dropped != '1)) begin
                stat_dropped <= stat_dropped + 32'd1;
            end
            if (count > stat_max_count) begin
                stat_max_count <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_event_fifo.sv
// Self-checking bench for conv_event_fifo: vector table, corner sequences, random vs queue model.
`timescale 1ns/1ps
module tb_conv_event_fifo;
    import snn_interfaces_pkg::*;

    localparam int DEPTH     = 16;
    localparam int ADDR_BITS = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    output_vector_t       in_event;
    logic                 out_valid;
    logic                 out_ready;
    output_vector_t       out_event;
    logic                 out_ts_new;
    logic [ADDR_BITS:0]   count;
    logic                 empty;
    logic                 full;
`ifdef CONV_EVENT_FIFO_STATS_EN
    logic [31:0]          stat_accepted;
    logic [31:0]          stat_dropped;
    logic [ADDR_BITS:0]   stat_max_count;
`endif

    conv_event_fifo #(
        .IN_CHANNELS (SPIKE_CHANNELS),
        .DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_event   (in_event),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_event  (out_event),
        .out_ts_new (out_ts_new),
        .count      (count),
        .empty      (empty),
        .full       (full)
`ifdef CONV_EVENT_FIFO_STATS_EN
        ,
        .stat_accepted  (stat_accepted),
        .stat_dropped   (stat_dropped),
        .stat_max_count (stat_max_count)
`endif
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: the FIFO is an ordered queue of non-empty events plus the last popped timestep.
    output_vector_t           model_q [$];
    logic [TIMESTEP_BITS-1:0] model_last_ts;
    bit                       model_last_valid;

    typedef struct {
        logic           v;
        output_vector_t ev;
        logic           rdy;
        logic           exp_valid;
        int             exp_x;
        logic           exp_ts_new;
        int             exp_count;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic output_vector_t mk_ev(input int ts, input int x, input int y, input int sp);
        output_vector_t ev;
        ev.timestep = TIMESTEP_BITS'(ts);
        ev.x        = COORD_BITS'(x);
        ev.y        = COORD_BITS'(y);
        ev.spikes   = SPIKE_CHANNELS'(sp);
        return ev;
    endfunction

    function automatic vec_t mk_vec(input logic v, input output_vector_t ev, input logic rdy,
                                    input logic exp_valid, input int exp_x, input logic exp_ts_new,
                                    input int exp_count);
        vec_t r;
        r.v = v; r.ev = ev; r.rdy = rdy;
        r.exp_valid = exp_valid; r.exp_x = exp_x; r.exp_ts_new = exp_ts_new; r.exp_count = exp_count;
        return r;
    endfunction

    task automatic model_reset();
        model_q.delete();
        model_last_ts    = '0;
        model_last_valid = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int occ;
        bit exp_ts_new;
        occ = model_q.size();
        exp_ts_new = 1'b0;
        if (occ > 0) begin
            exp_ts_new = !model_last_valid || (model_q[0].timestep != model_last_ts);
        end
        check({tag, " count"},      32'(count),      32'(occ));
        check({tag, " out_valid"},  32'(out_valid),  32'(occ > 0));
        check({tag, " in_ready"},   32'(in_ready),   32'(occ < DEPTH));
        check({tag, " empty"},      32'(empty),      32'(occ == 0));
        check({tag, " full"},       32'(full),       32'(occ == DEPTH));
        check({tag, " out_ts_new"}, 32'(out_ts_new), 32'(exp_ts_new));
        if (occ > 0) begin
            check({tag, " out_event"}, 32'(out_event), 32'(model_q[0]));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic cycle(input logic v, input output_vector_t ev, input logic rdy, input string tag);
        bit m_push;
        bit m_pop;
        in_valid  = v;
        in_event  = ev;
        out_ready = rdy;
        m_pop  = (model_q.size() > 0) && rdy;
        m_push = v && (model_q.size() < DEPTH) && (ev.spikes != '0);
        @(posedge clk);
        #1;
        if (m_pop) begin
            model_last_ts    = model_q[0].timestep;
            model_last_valid = 1'b1;
            void'(model_q.pop_front());
        end
        if (m_push) begin
            model_q.push_back(ev);
        end
        check_model(tag);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < DEPTH + 2 && model_q.size() > 0; k++) begin
            cycle(1'b0, mk_ev(0, 0, 0, 0), 1'b1, tag);
        end
        check({tag, " drained"}, 32'(empty), 32'(1));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_event  = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model("reset");

        // Single event, then empty-event filtering and the timestep-change pattern 1,0,1,0,1.
        vecs[0] = mk_vec(1'b1, mk_ev(0, 5, 3, 3),  1'b1, 1'b1, 5,  1'b1, 1);
        vecs[1] = mk_vec(1'b0, mk_ev(0, 0, 0, 0),  1'b1, 1'b0, 0,  1'b0, 0);
        vecs[2] = mk_vec(1'b1, mk_ev(1, 10, 0, 1), 1'b0, 1'b1, 10, 1'b1, 1);
        vecs[3] = mk_vec(1'b1, mk_ev(1, 11, 0, 0), 1'b0, 1'b1, 10, 1'b1, 1);
        vecs[4] = mk_vec(1'b1, mk_ev(1, 12, 0, 2), 1'b0, 1'b1, 10, 1'b1, 2);
        vecs[5] = mk_vec(1'b1, mk_ev(2, 13, 0, 3), 1'b1, 1'b1, 12, 1'b0, 2);
        vecs[6] = mk_vec(1'b1, mk_ev(2, 14, 0, 1), 1'b1, 1'b1, 13, 1'b1, 2);
        vecs[7] = mk_vec(1'b1, mk_ev(3, 15, 0, 1), 1'b1, 1'b1, 14, 1'b0, 2);
        vecs[8] = mk_vec(1'b0, mk_ev(0, 0, 0, 0),  1'b1, 1'b1, 15, 1'b1, 1);
        vecs[9] = mk_vec(1'b0, mk_ev(0, 0, 0, 0),  1'b1, 1'b0, 0,  1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].v, vecs[i].ev, vecs[i].rdy, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table out_valid", i),  32'(out_valid),  32'(vecs[i].exp_valid));
            check($sformatf("vec%0d table out_ts_new", i), 32'(out_ts_new), 32'(vecs[i].exp_ts_new));
            check($sformatf("vec%0d table count", i),      32'(count),      32'(vecs[i].exp_count));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d table x", i), 32'(out_event.x), 32'(vecs[i].exp_x));
            end
        end

        // Fill to DEPTH, stall a 17th event, then drain in push order.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, mk_ev(4, i, 0, 1), 1'b0, "fill");
        end
        check("fill full", 32'(full), 32'(1));
        check("fill in_ready", 32'(in_ready), 32'(0));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, mk_ev(5, 99, 7, 3), 1'b0, "stall");
        end
        cycle(1'b1, mk_ev(5, 99, 7, 3), 1'b1, "stall pop");
        check("stall pop count", 32'(count), 32'(DEPTH - 1));
        check("stall pop in_ready", 32'(in_ready), 32'(1));
        cycle(1'b1, mk_ev(5, 99, 7, 3), 1'b1, "stall push");
        check("stall push count", 32'(count), 32'(DEPTH - 1));
        drain("fill drain");

        // Steady push+pop at occupancy 8 across several pointer wraps.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, mk_ev(6, i, 1, 2), 1'b0, "wrap fill");
        end
        for (int j = 0; j < 40; j++) begin
            cycle(1'b1, mk_ev(6, 8 + j, 1, 2), 1'b1, "wrap");
            check("wrap count", 32'(count), 32'(8));
            check("wrap head x", 32'(out_event.x), 32'(j + 1));
        end
        drain("wrap drain");

        // Asynchronous reset with 5 stored events; the same timestep afterwards is still new.
        cycle(1'b1, mk_ev(9, 1, 0, 1), 1'b0, "pre-rst push");
        cycle(1'b0, mk_ev(0, 0, 0, 0), 1'b1, "pre-rst pop");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, mk_ev(9, 20 + i, 0, 1), 1'b0, "pre-rst fill");
        end
        check("pre-rst count", 32'(count), 32'(5));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async rst empty", 32'(empty), 32'(1));
        check("async rst out_valid", 32'(out_valid), 32'(0));
        check("async rst count", 32'(count), 32'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        cycle(1'b1, mk_ev(9, 30, 0, 1), 1'b0, "post-rst push");
        check("post-rst out_ts_new", 32'(out_ts_new), 32'(1));
        check("post-rst x", 32'(out_event.x), 32'(30));
        drain("post-rst drain");

        // Random traffic: slow consumer first to reach full, then faster consumer.
        begin
            int rts;
            rts = 10;
            for (int j = 0; j < 600; j++) begin
                logic v;
                logic rdy;
                if ($urandom_range(0, 7) == 0) rts++;
                v   = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 99) < (j < 250 ? 30 : 70));
                cycle(v, mk_ev(rts, j, $urandom_range(0, 255), $urandom_range(0, 3)), rdy, "rand");
            end
            drain("rand drain");
        end

`ifdef CONV_EVENT_FIFO_STATS_EN
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 13; i++) begin
            cycle(1'b1, mk_ev(1, i, 0, (i % 4 == 3) ? 0 : 1), 1'b0, "stats");
        end
        cycle(1'b0, mk_ev(0, 0, 0, 0), 1'b0, "stats idle");
        check("stat_accepted", stat_accepted, 32'd10);
        check("stat_dropped", stat_dropped, 32'd3);
        check("stat_max_count", 32'(stat_max_count), 32'd10);
        drain("stats drain");
`endif

        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
